// File: rtl/counter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_pkg : shared mode/direction encodings for mod_counter
// Revision    : 1.0
// ---------------------------------------------------------------------------
package counter_pkg;

   typedef enum logic {MODE_WRAP, MODE_ONESHOT} cnt_mode_e;
   typedef enum logic {DIR_UP, DIR_DOWN} cnt_dir_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mod_counter : programmable modulus up/down counter, wrap or one-shot
// Revision    : 1.0
// ---------------------------------------------------------------------------
module mod_counter
   import counter_pkg::*;
#(
   parameter int unsigned      WIDTH       = 8,
   parameter longint unsigned  DEFAULT_MAX = (64'd1 << WIDTH) - 64'd1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] max_value,
   input  logic             mode,
   input  logic             dir,
   output logic [WIDTH-1:0] value,
   output logic             tc,
   output logic             done
);

   localparam logic [WIDTH-1:0] DEF_MAX = DEFAULT_MAX[WIDTH-1:0];

   if (WIDTH < 1) begin : g_bad_width
      $error("mod_counter: WIDTH must be at least 1");
   end
   if (WIDTH < 64) begin : g_max_check
      if (DEFAULT_MAX >= (64'd1 << WIDTH)) begin : g_bad_default_max
         $error("mod_counter: DEFAULT_MAX does not fit in WIDTH bits");
      end
   end

   cnt_mode_e        mode_e;
   cnt_dir_e         dir_e;
   logic [WIDTH-1:0] max_q;
   logic [WIDTH-1:0] value_d;
   logic [WIDTH-1:0] max_d;
   logic             tc_d;
   logic             done_d;
   logic             term;

   assign mode_e = cnt_mode_e'(mode);
   assign dir_e  = cnt_dir_e'(dir);
   // ">=" rather than "==" so a load above the modulus still terminates
   assign term   = (dir_e == DIR_UP) ? (value >= max_q) : (value == '0);

   always_comb begin
      value_d = value;
      max_d   = max_q;
      tc_d    = 1'b0;
      done_d  = done;
      if (clr) begin
         value_d = '0;
         done_d  = 1'b0;
         max_d   = max_value;
      end else if (load) begin
         value_d = load_value;
         done_d  = 1'b0;
         max_d   = max_value;
      end else if (en && !done) begin
         if (term) begin
            tc_d = 1'b1;
            if (mode_e == MODE_ONESHOT) begin
               done_d = 1'b1;
            end else begin
               value_d = (dir_e == DIR_UP) ? '0 : max_value;
               max_d   = max_value;
            end
         end else begin
            value_d = (dir_e == DIR_UP) ? value + WIDTH'(1) : value - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value <= '0;
         tc    <= 1'b0;
         done  <= 1'b0;
         max_q <= DEF_MAX;
      end else begin
         value <= value_d;
         tc    <= tc_d;
         done  <= done_d;
         max_q <= max_d;
      end
   end

endmodule : mod_counter
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mod_counter : vector-table bench with expected-result queue, WIDTH=4
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_mod_counter;

   localparam int W = 4;

   typedef struct {
      logic         rst_n, en, clr, load;
      logic [W-1:0] load_value, max_value;
      logic         mode, dir;
      logic [W-1:0] exp_value;
      logic         exp_tc, exp_done;
      string        name;
   } vec_t;

   typedef struct {
      logic [W-1:0] value;
      logic         tc, done;
      string        name;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n, en, clr, load, mode, dir;
   logic [W-1:0] load_value, max_value, value;
   logic         tc, done;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mod_counter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
      .load_value(load_value), .max_value(max_value), .mode(mode), .dir(dir),
      .value(value), .tc(tc), .done(done)
   );

   // r=rst_n e=en c=clr l=load lv=load_value mx=max_value md=mode dr=dir
   function automatic void add(string nm, logic r, logic e, logic c, logic l,
                               int lv, int mx, logic md, logic dr,
                               int ev, logic et, logic ed);
      vec_t v;
      v.name = nm; v.rst_n = r; v.en = e; v.clr = c; v.load = l;
      v.load_value = W'(lv); v.max_value = W'(mx); v.mode = md; v.dir = dr;
      v.exp_value = W'(ev); v.exp_tc = et; v.exp_done = ed;
      vecs.push_back(v);
   endfunction

   task automatic check_out();
      exp_t x;
      if (sb.size() == 0) begin
         n_cmp++; n_fail++;
         $display("FAIL scoreboard_empty: no expected entry queued");
         return;
      end
      x = sb.pop_front();
      n_cmp++;
      if (value !== x.value) begin
         n_fail++;
         $display("FAIL %s value: got %0d want %0d", x.name, value, x.value);
      end
      n_cmp++;
      if (tc !== x.tc) begin
         n_fail++;
         $display("FAIL %s tc: got %b want %b", x.name, tc, x.tc);
      end
      n_cmp++;
      if (done !== x.done) begin
         n_fail++;
         $display("FAIL %s done: got %b want %b", x.name, done, x.done);
      end
   endtask

   task automatic apply(input vec_t v);
      exp_t x;
      @(negedge clk);
      rst_n = v.rst_n; en = v.en; clr = v.clr; load = v.load;
      load_value = v.load_value; max_value = v.max_value;
      mode = v.mode; dir = v.dir;
      x.value = v.exp_value; x.tc = v.exp_tc; x.done = v.exp_done; x.name = v.name;
      sb.push_back(x);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0; en = 1'b1; clr = 1'b0; load = 1'b0;
      load_value = '0; max_value = '0; mode = 1'b0; dir = 1'b0;

      // reset with en held, then first step counts against DEFAULT_MAX
      add("rst0",  0,1,0,0, 0,5,0,0, 0,0,0);
      add("rst1",  0,1,0,0, 0,5,0,0, 0,0,0);
      add("first", 1,1,0,0, 0,5,0,0, 1,0,0);
      // modulus 5 up/wrap
      add("clr5",  1,0,1,0, 0,5,0,0, 0,0,0);
      for (int k = 0; k < 12; k++)
         add("up5", 1,1,0,0, 0,5,0,0, (k % 6 == 5) ? 0 : (k % 6) + 1,
             (k % 6 == 5), 0);
      // down one-shot from 3
      add("ld3",   1,0,0,1, 3,3,1,1, 3,0,0);
      add("dn2",   1,1,0,0, 0,3,1,1, 2,0,0);
      add("dn1",   1,1,0,0, 0,3,1,1, 1,0,0);
      add("dn0",   1,1,0,0, 0,3,1,1, 0,0,0);
      add("osterm",1,1,0,0, 0,3,1,1, 0,1,1);
      add("oshold",1,1,0,0, 0,3,1,1, 0,0,1);
      add("osidle",1,0,0,0, 0,3,1,1, 0,0,1);
      add("ldrel", 1,1,0,1, 5,3,1,1, 5,0,0);
      add("dnabv", 1,1,0,0, 0,3,1,1, 4,0,0);
      // retune mid-count: old modulus 9 runs out before 2 takes over
      add("clr9",  1,0,1,0, 0,9,0,0, 0,0,0);
      for (int k = 1; k <= 4; k++) add("up9", 1,1,0,0, 0,9,0,0, k,0,0);
      for (int k = 5; k <= 9; k++) add("up9r",1,1,0,0, 0,2,0,0, k,0,0);
      add("wrap9", 1,1,0,0, 0,2,0,0, 0,1,0);
      add("up2a",  1,1,0,0, 0,2,0,0, 1,0,0);
      add("up2b",  1,1,0,0, 0,2,0,0, 2,0,0);
      add("wrap2", 1,1,0,0, 0,2,0,0, 0,1,0);
      // clr beats load beats en; clr re-samples max
      add("ld7",   1,0,0,1, 7,9,0,0, 7,0,0);
      add("clrall",1,1,1,1, 3,9,0,0, 0,0,0);
      add("ld1",   1,1,0,1, 1,9,0,0, 1,0,0);
      add("clr3",  1,0,1,0, 0,3,0,0, 0,0,0);
      add("up3a",  1,1,0,0, 0,9,0,0, 1,0,0);
      add("up3b",  1,1,0,0, 0,9,0,0, 2,0,0);
      add("up3c",  1,1,0,0, 0,9,0,0, 3,0,0);
      add("wrap3", 1,1,0,0, 0,9,0,0, 0,1,0);
      add("idle",  1,0,0,0, 0,9,0,0, 0,0,0);
      // zero modulus
      add("clr0",  1,0,1,0, 0,0,0,0, 0,0,0);
      for (int k = 0; k < 3; k++) add("max0", 1,1,0,0, 0,0,0,0, 0,1,0);
      add("max0off",1,0,0,0, 0,0,0,0, 0,0,0);
      // down wrap reloads from live max_value
      add("clrd",  1,0,1,0, 0,2,0,1, 0,0,0);
      add("dwrap", 1,1,0,0, 0,2,0,1, 2,1,0);
      add("dw1",   1,1,0,0, 0,2,0,1, 1,0,0);
      add("dw0",   1,1,0,0, 0,2,0,1, 0,0,0);
      add("dlive", 1,1,0,0, 0,3,0,1, 3,1,0);

      foreach (vecs[i]) apply(vecs[i]);

      // done stays sticky whatever en/dir/mode do until load arrives
      v = vecs[0];
      v.rst_n = 1; v.clr = 0; v.load = 1; v.load_value = 1; v.max_value = 1;
      v.mode = 1; v.dir = 0; v.en = 0;
      v.exp_value = 1; v.exp_tc = 0; v.exp_done = 0; v.name = "stk_ld";
      apply(v);
      v.load = 0; v.en = 1; v.exp_tc = 1; v.exp_done = 1; v.name = "stk_term";
      apply(v);
      for (int k = 0; k < 10; k++) begin
         v.en = 1'($urandom_range(0, 1)); v.dir = 1'($urandom_range(0, 1));
         v.mode = 1'($urandom_range(0, 1)); v.max_value = W'($urandom_range(0, 15));
         v.exp_tc = 0; v.name = "stk_hold";
         apply(v);
      end
      v.clr = 1; v.exp_value = 0; v.exp_done = 0; v.name = "stk_clr";
      apply(v);

      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_mod_counter
`default_nettype wire
